alu_issue_ctrl: RTL

- Issue/response sequencer directly upstream of the 32-bit CLA ALU.
- Accepts one operation request per transaction over a valid/ready handshake and drives A, B and ALUOp to the ALU.
- Holds those inputs stable until the ALU's We indicates a valid Result; for the multi-cycle MOD, that can take many cycles.
- Captures Result and C, returns them with the request tag over a second valid/ready handshake, and guards MOD with divide-by-zero rejection and a watchdog.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_issue_watchdog.sv | 47 ++++
 rtl/alu_issue_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue controller and its watchdog:
//   - DATA_W   : ALU datapath width
//   - alu_op_e : ALUOp encodings (OP_AND .. OP_MOD)
//   - state_e  : issue controller FSM states
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_NOR = 3'b011,
        OP_SLT = 3'b100,
        OP_ADD = 3'b101,
        OP_SUB = 3'b110,
        OP_MOD = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue_watchdog.sv
// ---------------------------------------------------------------------------
// alu_issue_watchdog
// Saturating EXEC-cycle counter used to abort an operation the ALU never
// completes.
// Ports:
//   Clk, Reset   : clock, asynchronous active-high reset
//   i_clr        : clear the count to zero (has priority)
//   i_load       : load i_load_val
//   i_load_val   : value for i_load
//   i_en         : count this cycle (one EXEC cycle)
//   o_count      : EXEC cycles already completed before the current one
//   o_expired    : the current enabled cycle is the TIMEOUT_CYCLES-th one
// ---------------------------------------------------------------------------
module alu_issue_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt lags the 1-based EXEC cycle index by one, so the TIMEOUT_CYCLES-th
    // cycle is the one that sees TIMEOUT_CYCLES-1 here.
    assign o_count   = r_cnt;
    assign o_expired = i_en && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Issue/response sequencer in front of the 32-bit CLA ALU. Accepts one
// request, holds A/B/ALUOp stable until the ALU raises We, captures Result/C
// and returns them with the request tag. MOD by zero is rejected without
// issuing; a watchdog aborts operations that never complete.
// Ports:
//   Clk, Reset                       : clock, asynchronous active-high reset
//   req_valid/req_ready              : request handshake
//   req_a, req_b, req_op, req_tag    : request payload
//   alu_a, alu_b, alu_op             : operands/opcode to the ALU
//   alu_result, alu_c, alu_we        : ALU result, carry, result-valid
//   rsp_valid/rsp_ready              : response handshake
//   rsp_result, rsp_c, rsp_tag, rsp_err : response payload
//   busy                             : controller not in IDLE
// Optional (macro ALU_ISSUE_STATS_EN): stat_ops, stat_errs, stat_busy_cycles
// saturating counters of good responses, error responses and busy cycles.
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [2:0]        req_op,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_c,
    input  logic              alu_we,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_c,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic              busy
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]       stat_ops,
    output logic [15:0]       stat_errs,
    output logic [31:0]       stat_busy_cycles
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e            r_state;
    state_e            w_next;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [2:0]        r_op;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_c;
    logic [TAG_W-1:0]  r_rsp_tag;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_div0;
    logic              w_exec;
    logic              w_settle;
    logic              w_capture;
    logic              w_timeout;
    logic              w_rsp_hs;
    logic [CNT_W-1:0]  w_wd_count;
    logic              w_wd_expired;

    assign w_exec   = (r_state == EXEC);
    assign w_accept = req_valid && (r_state == IDLE);
    assign w_div0   = (req_op == OP_MOD) && (req_b == '0);
    assign w_rsp_hs = (r_state == DONE) && rsp_ready;

    // The ALU's MOD unit may still show a stale We in the cycle its operands
    // first arrive, so MOD ignores We during its first EXEC cycle.
    assign w_settle  = (r_op == OP_MOD) && (w_wd_count == '0);
    assign w_capture = w_exec && alu_we && !w_settle;
    // A capture in the expiry cycle takes precedence over the abort.
    assign w_timeout = w_wd_expired && !w_capture;

    alu_issue_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_clr      (w_accept),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_exec),
        .o_count    (w_wd_count),
        .o_expired  (w_wd_expired)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = w_div0 ? DONE : EXEC;
            EXEC: if (w_capture || w_timeout) w_next = DONE;
            DONE: if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_tag <= '0;
        end else if (w_accept) begin
            r_a   <= req_a;
            r_b   <= req_b;
            r_op  <= req_op;
            r_tag <= req_tag;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rsp_result <= '0;
            r_rsp_c      <= 1'b0;
            r_rsp_tag    <= '0;
            r_rsp_err    <= 1'b0;
        end else if (w_accept && w_div0) begin
            r_rsp_result <= '0;
            r_rsp_c      <= 1'b0;
            r_rsp_tag    <= req_tag;
            r_rsp_err    <= 1'b1;
        end else if (w_capture) begin
            r_rsp_result <= alu_result;
            r_rsp_c      <= alu_c;
            r_rsp_tag    <= r_tag;
            r_rsp_err    <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_result <= '0;
            r_rsp_c      <= 1'b0;
            r_rsp_tag    <= r_tag;
            r_rsp_err    <= 1'b1;
        end
    end

    // Opcode is only presented while executing so a held MOD never retriggers.
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_op     = w_exec ? r_op : OP_AND;
    assign req_ready  = (r_state == IDLE);
    assign rsp_valid  = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign rsp_result = r_rsp_result;
    assign rsp_c      = r_rsp_c;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_err    = r_rsp_err;

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] r_stat_ops;
    logic [15:0] r_stat_errs;
    logic [31:0] r_stat_busy;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_stat_ops  <= '0;
            r_stat_errs <= '0;
            r_stat_busy <= '0;
        end else begin
            if (w_rsp_hs && !r_rsp_err && (r_stat_ops != '1))
                r_stat_ops <= r_stat_ops + 32'd1;
            if (w_rsp_hs && r_rsp_err && (r_stat_errs != '1))
                r_stat_errs <= r_stat_errs + 16'd1;
            if (busy && (r_stat_busy != '1))
                r_stat_busy <= r_stat_busy + 32'd1;
        end
    end

    assign stat_ops         = r_stat_ops;
    assign stat_errs        = r_stat_errs;
    assign stat_busy_cycles = r_stat_busy;
`endif

endmodule
